// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states, op decode.
package lsu_pkg;

  localparam logic [2:0] OP_B  = 3'b000;
  localparam logic [2:0] OP_H  = 3'b001;
  localparam logic [2:0] OP_W  = 3'b010;
  localparam logic [2:0] OP_BU = 3'b100;
  localparam logic [2:0] OP_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETTLE0 = 3'd1,
    WAIT0   = 3'd2,
    SETTLE1 = 3'd3,
    WAIT1   = 3'd4,
    DONE    = 3'd5
  } state_t;

  typedef struct packed {
    logic       illegal;
    logic [2:0] size;
  } decode_t;

  // Access size in bytes and legality; unsigned variants exist only for loads.
  function automatic decode_t decode_op(input logic write, input logic [2:0] op);
    decode_t d;
    d.illegal = 1'b0;
    d.size    = 3'd4;
    case (op)
      OP_B:  d.size = 3'd1;
      OP_H:  d.size = 3'd2;
      OP_W:  d.size = 3'd4;
      OP_BU: begin d.size = 3'd1; d.illegal = write; end
      OP_HU: begin d.size = 3'd2; d.illegal = write; end
      default: d.illegal = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store mask/data spread over two words, load extract/extend.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [1:0]  offset,
  input  logic [2:0]  size,
  input  logic [31:0] st_data,
  input  logic [31:0] ld_lo,
  input  logic [31:0] ld_hi,
  output logic [7:0]  mask8,
  output logic [63:0] data64,
  output logic [31:0] ld_result
);

  logic [7:0]  base;
  logic [31:0] shifted;

  // Build the 8-lane mask and shifted store data; extract and extend load bytes.
  always_comb begin
    case (size)
      3'd1:    base = 8'h01;
      3'd2:    base = 8'h03;
      default: base = 8'h0F;
    endcase
    mask8   = base << offset;
    data64  = {32'd0, st_data} << {offset, 3'b000};
    shifted = 32'({ld_hi, ld_lo} >> {offset, 3'b000});
    case (op)
      OP_B:    ld_result = {{24{shifted[7]}}, shifted[7:0]};
      OP_H:    ld_result = {{16{shifted[15]}}, shifted[15:0]};
      OP_BU:   ld_result = {24'd0, shifted[7:0]};
      OP_HU:   ld_result = {16'd0, shifted[15:0]};
      default: ld_result = shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Turns byte/half/word CPU accesses into one or two word-aligned cache accesses,
// holding the cache command stable while busy and returning one response each.
module load_store_unit
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_address,
  input  logic [31:0] req_data,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_error,
  output logic        c_enable,
  output logic [31:0] c_address,
  output logic [31:0] c_data_in,
  output logic [3:0]  c_write_enable,
  input  logic [31:0] c_data_out,
  input  logic        c_data_out_ready,
  input  logic        c_busy
);

  state_t      state, state_nx;
  decode_t     req_dec;
  logic [3:0]  req_end;
  logic        req_split;

  logic        q_write, q_split;
  logic [2:0]  q_op, q_size;
  logic [1:0]  q_off;
  logic [31:0] q_word0, q_data, q_lo;

  logic [2:0]  a_op, a_size;
  logic [1:0]  a_off;
  logic [31:0] a_data, a_lo;
  logic [7:0]  mask8;
  logic [63:0] data64;
  logic [31:0] ld_result;
  logic        wait_ok;

  assign req_dec   = decode_op(req_write, req_op);
  assign req_end   = {2'b00, req_address[1:0]} + {1'b0, req_dec.size};
  assign req_split = (req_end > 4'd4);

  // In IDLE the aligner sees the incoming request; afterwards the latched one.
  assign a_op   = (state == IDLE) ? req_op              : q_op;
  assign a_off  = (state == IDLE) ? req_address[1:0]    : q_off;
  assign a_size = (state == IDLE) ? req_dec.size        : q_size;
  assign a_data = (state == IDLE) ? req_data            : q_data;
  assign a_lo   = (state == WAIT1) ? q_lo : c_data_out;

  // A load needs read data; a store is committed once the cache is no longer busy.
  assign wait_ok = !c_busy && (q_write || c_data_out_ready);

  lsu_align u_align (
    .op        (a_op),
    .offset    (a_off),
    .size      (a_size),
    .st_data   (a_data),
    .ld_lo     (a_lo),
    .ld_hi     (c_data_out),
    .mask8     (mask8),
    .data64    (data64),
    .ld_result (ld_result)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nx  = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nx = req_dec.illegal ? DONE : SETTLE0;
      end
      SETTLE0: state_nx = WAIT0;
      WAIT0:   if (wait_ok) state_nx = q_split ? SETTLE1 : DONE;
      SETTLE1: state_nx = WAIT1;
      WAIT1:   if (wait_ok) state_nx = DONE;
      DONE: begin
        rsp_valid = 1'b1;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Request latch, cache command registers and registered response.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_write        <= 1'b0;
      q_split        <= 1'b0;
      q_op           <= 3'd0;
      q_size         <= 3'd0;
      q_off          <= 2'd0;
      q_word0        <= 32'd0;
      q_data         <= 32'd0;
      q_lo           <= 32'd0;
      c_enable       <= 1'b0;
      c_address      <= 32'd0;
      c_data_in      <= 32'd0;
      c_write_enable <= 4'd0;
      rsp_data       <= 32'd0;
      rsp_error      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            q_write <= req_write;
            q_split <= req_split;
            q_op    <= req_op;
            q_size  <= req_dec.size;
            q_off   <= req_address[1:0];
            q_word0 <= {req_address[31:2], 2'b00};
            q_data  <= req_data;
            if (req_dec.illegal) begin
              rsp_error <= 1'b1;
              rsp_data  <= 32'd0;
            end else begin
              c_enable       <= 1'b1;
              c_address      <= {req_address[31:2], 2'b00};
              c_data_in      <= data64[31:0];
              c_write_enable <= req_write ? mask8[3:0] : 4'd0;
            end
          end
        end
        WAIT0: begin
          if (wait_ok) begin
            q_lo <= c_data_out;
            if (q_split) begin
              c_address      <= q_word0 + 32'd4;
              c_data_in      <= data64[63:32];
              c_write_enable <= q_write ? mask8[7:4] : 4'd0;
            end else begin
              c_enable       <= 1'b0;
              c_write_enable <= 4'd0;
              rsp_error      <= 1'b0;
              rsp_data       <= q_write ? 32'd0 : ld_result;
            end
          end
        end
        WAIT1: begin
          if (wait_ok) begin
            c_enable       <= 1'b0;
            c_write_enable <= 4'd0;
            rsp_error      <= 1'b0;
            rsp_data       <= q_write ? 32'd0 : ld_result;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: a 1 KB byte-level reference memory and a simple
// cache model with programmable miss lengths per access.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [2:0]  req_op;
  logic [31:0] req_address, req_data;
  logic        rsp_valid, rsp_error;
  logic [31:0] rsp_data;
  logic        c_enable;
  logic [31:0] c_address, c_data_in, c_data_out;
  logic [3:0]  c_write_enable;
  logic        c_data_out_ready, c_busy;

  int n_cmp = 0;
  int n_err = 0;

  // cache model state
  logic [31:0] mem [0:255];
  logic [7:0]  ref_mem [0:1023];
  int          cnt;
  int          miss0, miss1;
  int          acc_idx;
  logic        en_d;
  logic [31:0] addr_d;
  logic [31:0] acc_a [0:1];
  logic [3:0]  acc_we [0:1];
  logic [31:0] acc_d [0:1];
  logic        bd_en;
  logic [7:0]  bd_idx;
  logic [31:0] bd_val;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_op(req_op), .req_address(req_address), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_error(rsp_error),
    .c_enable(c_enable), .c_address(c_address), .c_data_in(c_data_in),
    .c_write_enable(c_write_enable), .c_data_out(c_data_out),
    .c_data_out_ready(c_data_out_ready), .c_busy(c_busy)
  );

  assign c_busy           = (cnt != 0);
  assign c_data_out_ready = (cnt == 0);
  assign c_data_out       = mem[c_address[9:2]];

  // Cache model: a new address starts an access with the programmed miss length.
  always @(posedge clk) begin
    if (bd_en) mem[bd_idx] <= bd_val;
    if (rst) begin
      cnt <= 0; en_d <= 1'b0; addr_d <= 32'd0; acc_idx <= 0;
    end else begin
      if (c_enable && (!en_d || c_address != addr_d)) begin
        cnt <= (acc_idx == 0) ? miss0 : miss1;
        acc_a[acc_idx[0]]  <= c_address;
        acc_we[acc_idx[0]] <= c_write_enable;
        acc_d[acc_idx[0]]  <= c_data_in;
        acc_idx <= 1;
      end else if (cnt != 0) begin
        cnt <= cnt - 1;
      end
      if (!c_enable) acc_idx <= 0;
      if (c_enable && cnt == 0)
        for (int b = 0; b < 4; b++)
          if (c_write_enable[b]) mem[c_address[9:2]][8*b +: 8] <= c_data_in[8*b +: 8];
      en_d   <= c_enable;
      addr_d <= c_address;
    end
  end

  function automatic int op_size(input logic [2:0] op);
    if (op[1:0] == 2'b00) return 1;
    if (op[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic op_illegal(input logic w, input logic [2:0] op);
    if (w) return (op >= 3'd3);
    return (op == 3'd3 || op == 3'd6 || op == 3'd7);
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [31:0] a);
    logic [31:0] v;
    logic [31:0] ai;
    v = 32'd0;
    for (int i = 0; i < op_size(op); i++) begin
      ai = a + 32'(i);
      v[8*i +: 8] = ref_mem[ai[9:0]];
    end
    if (op == 3'b000) v = {{24{v[7]}}, v[7:0]};
    if (op == 3'b001) v = {{16{v[15]}}, v[15:0]};
    return v;
  endfunction

  task automatic ref_store(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] ai;
    for (int i = 0; i < op_size(op); i++) begin
      ai = a + 32'(i);
      ref_mem[ai[9:0]] = d[8*i +: 8];
    end
  endtask

  task automatic set_word(input logic [31:0] a, input logic [31:0] v);
    @(negedge clk);
    bd_en = 1'b1; bd_idx = a[9:2]; bd_val = v;
    @(posedge clk);
    #1 bd_en = 1'b0;
    for (int i = 0; i < 4; i++) ref_mem[{a[9:2], 2'(i)}] = v[8*i +: 8];
  endtask

  // One request with model-derived response, latency and command-hold checks.
  task automatic run_req(input logic w, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] d, input int m0, input int m1,
                         output logic [31:0] got, output int lat);
    logic        ill, split, gerr, seen_en, p_en, p_busy;
    logic [31:0] exp_d, p_a, p_d;
    logic [3:0]  p_we;
    int          exp_lat;
    ill     = op_illegal(w, op);
    split   = (int'(a[1:0]) + op_size(op)) > 4;
    exp_lat = ill ? 1 : (3 + m0 + (split ? 2 + m1 : 0));
    exp_d   = (ill || w) ? 32'd0 : ref_load(op, a);
    miss0 = m0; miss1 = m1;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 1'b1) begin n_err++; $display("FAIL ready_idle got=%b want=1", req_ready); end
    req_valid = 1'b1; req_write = w; req_op = op; req_address = a; req_data = d;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0; got = 32'd0; gerr = 1'b0; seen_en = 1'b0;
    p_en = 1'b0; p_busy = 1'b0; p_a = 32'd0; p_d = 32'd0; p_we = 4'd0;
    for (int k = 1; k <= 200 && lat == 0; k++) begin
      @(negedge clk);
      if (c_enable) begin
        seen_en = 1'b1;
        n_cmp++;
        if (c_address[1:0] != 2'b00 || (!w && c_write_enable != 4'd0) ||
            (p_en && p_busy && {c_address, c_data_in, c_write_enable} !== {p_a, p_d, p_we})) begin
          n_err++;
          $display("FAIL cmd_hold cyc=%0d addr=%h we=%b data=%h prev addr=%h we=%b data=%h",
                   k, c_address, c_write_enable, c_data_in, p_a, p_we, p_d);
        end
      end
      if (rsp_valid) begin lat = k; got = rsp_data; gerr = rsp_error; end
      p_en = c_enable; p_busy = c_busy; p_a = c_address; p_d = c_data_in; p_we = c_write_enable;
    end
    n_cmp++;
    if (lat != exp_lat) begin
      n_err++;
      $display("FAIL latency w=%b op=%0d a=%h got=%0d want=%0d (0=timeout)", w, op, a, lat, exp_lat);
    end
    n_cmp++;
    if (got !== exp_d) begin
      n_err++; $display("FAIL rsp_data w=%b op=%0d a=%h got=%h want=%h", w, op, a, got, exp_d);
    end
    n_cmp++;
    if (gerr !== ill) begin
      n_err++; $display("FAIL rsp_error w=%b op=%0d got=%b want=%b", w, op, gerr, ill);
    end
    if (ill) begin
      n_cmp++;
      if (seen_en) begin n_err++; $display("FAIL illegal_no_access got=1 want=0"); end
    end
    @(negedge clk);
    n_cmp++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_err++; $display("FAIL rsp_pulse rsp_valid=%b req_ready=%b want 0/1", rsp_valid, req_ready);
    end
    if (w && !ill) ref_store(op, a, d);
  endtask

  task automatic check_reset_outputs(input string tag);
    n_cmp++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_data !== 32'd0 || rsp_error !== 1'b0 ||
        c_enable !== 1'b0 || c_write_enable !== 4'd0 || c_address !== 32'd0 || c_data_in !== 32'd0) begin
      n_err++;
      $display("FAIL %s rdy=%b vld=%b data=%h err=%b en=%b we=%b addr=%h din=%h (want 1,0,0,0,0,0,0,0)",
               tag, req_ready, rsp_valid, rsp_data, rsp_error, c_enable, c_write_enable,
               c_address, c_data_in);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("reset_state");
    rst = 1'b0;
    for (int w = 0; w < 256; w++) set_word(32'(w) << 2, $urandom);
  endtask

  task automatic test_lw_hit();
    logic [31:0] g; int l;
    set_word(32'h100, 32'hDEADBEEF);
    run_req(1'b0, 3'b010, 32'h100, 32'd0, 0, 0, g, l);
    n_cmp++;
    if (g !== 32'hDEADBEEF || l != 3) begin
      n_err++; $display("FAIL lw_0x100 data=%h lat=%0d want DEADBEEF/3", g, l);
    end
  endtask

  task automatic test_lb_sign();
    logic [31:0] g; int l;
    set_word(32'h100, 32'h80FFFFFF);
    run_req(1'b0, 3'b000, 32'h103, 32'd0, 1, 0, g, l);
    n_cmp++;
    if (g !== 32'hFFFFFF80) begin n_err++; $display("FAIL lb_0x103 got=%h want=FFFFFF80", g); end
    run_req(1'b0, 3'b100, 32'h103, 32'd0, 0, 0, g, l);
    n_cmp++;
    if (g !== 32'h00000080) begin n_err++; $display("FAIL lbu_0x103 got=%h want=00000080", g); end
  endtask

  task automatic test_sw_split();
    logic [31:0] g; int l;
    run_req(1'b1, 3'b010, 32'h102, 32'h11223344, 0, 0, g, l);
    n_cmp++;
    if (acc_a[0] !== 32'h100 || acc_we[0] !== 4'b1100 || acc_d[0] !== 32'h33440000 ||
        acc_a[1] !== 32'h104 || acc_we[1] !== 4'b0011 || acc_d[1] !== 32'h00001122 || l != 5) begin
      n_err++;
      $display("FAIL sw_split a0=%h/%b/%h a1=%h/%b/%h lat=%0d", acc_a[0], acc_we[0], acc_d[0],
               acc_a[1], acc_we[1], acc_d[1], l);
    end
  endtask

  task automatic test_lh_wrap();
    logic [31:0] g; int l;
    set_word(32'hFFFFFFFC, 32'hAB000000);
    set_word(32'h0, 32'h000000CD);
    run_req(1'b0, 3'b001, 32'hFFFFFFFF, 32'd0, 0, 2, g, l);
    n_cmp++;
    if (g !== 32'hFFFFCDAB || acc_a[0] !== 32'hFFFFFFFC || acc_a[1] !== 32'h0) begin
      n_err++; $display("FAIL lh_wrap data=%h a0=%h a1=%h want FFFFCDAB/FFFFFFFC/0", g, acc_a[0], acc_a[1]);
    end
  endtask

  task automatic test_sb_miss();
    logic [31:0] g; int l;
    run_req(1'b1, 3'b000, 32'h205, 32'h0000005A, 20, 0, g, l);
    n_cmp++;
    if (acc_a[0] !== 32'h204 || acc_we[0] !== 4'b0010 || acc_d[0] !== 32'h00005A00 || l != 23) begin
      n_err++; $display("FAIL sb_miss a=%h we=%b d=%h lat=%0d want 204/0010/00005A00/23",
                        acc_a[0], acc_we[0], acc_d[0], l);
    end
  endtask

  task automatic test_illegal();
    logic [31:0] g; int l;
    run_req(1'b0, 3'b011, 32'h40, 32'd0, 0, 0, g, l);
    run_req(1'b1, 3'b100, 32'h41, 32'hFFFF, 0, 0, g, l);
  endtask

  task automatic test_reset_in_wait1();
    miss0 = 0; miss1 = 10;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_op = 3'b010; req_address = 32'h1FE; req_data = 32'd0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (5) @(negedge clk);
    n_cmp++;
    if (c_enable !== 1'b1 || c_address !== 32'h200 || rsp_valid !== 1'b0) begin
      n_err++; $display("FAIL pre_reset_wait1 en=%b addr=%h vld=%b want 1/200/0", c_enable, c_address, rsp_valid);
    end
    rst = 1'b1;
    @(posedge clk);
    #1 check_reset_outputs("reset_in_wait1");
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] g; int l;
    for (int i = 0; i < 200; i++)
      run_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 32'($urandom_range(0, 1023)),
              $urandom, $urandom_range(0, 3), $urandom_range(0, 3), g, l);
  endtask

  task automatic test_mem_contents();
    logic [31:0] e;
    for (int w = 0; w < 256; w++) begin
      for (int i = 0; i < 4; i++) e[8*i +: 8] = ref_mem[4*w + i];
      n_cmp++;
      if (mem[w] !== e) begin n_err++; $display("FAIL mem_word idx=%0d got=%h want=%h", w, mem[w], e); end
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_op = 3'd0;
    req_address = 32'd0; req_data = 32'd0; bd_en = 1'b0; bd_idx = 8'd0; bd_val = 32'd0;
    miss0 = 0; miss1 = 0;
    test_reset();
    test_lw_hit();
    test_lb_sign();
    test_sw_split();
    test_lh_wrap();
    test_sb_miss();
    test_illegal();
    test_reset_in_wait1();
    test_random();
    test_mem_contents();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
